// File: rtl/acc_core_pkg.sv
// Shared opcodes, run-control states and instruction-register flags for the
// programmable accumulator core.
package acc_core_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_SLL  = 4'h2;
  localparam logic [3:0] OP_BNZ  = 4'h3;
  localparam logic [3:0] OP_SRL  = 4'h4;
  localparam logic [3:0] OP_MUL  = 4'h5;
  localparam logic [3:0] OP_NAND = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LI   = 4'h9;
  localparam logic [3:0] OP_SLLI = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hC;
  localparam logic [3:0] OP_CLR  = 4'hD;
  localparam logic [3:0] OP_LA   = 4'hE;
  localparam logic [3:0] OP_SA   = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } run_state_t;

  // An empty IR slot is the pipeline's NOP; flushing simply clears the flag.
  localparam logic IR_INVALID = 1'b0;
  localparam logic IR_VALID   = 1'b1;

  function automatic logic writes_acc(input logic [3:0] opcode);
    return !(opcode inside {OP_BNZ, OP_JMP, OP_HALT, OP_SA});
  endfunction

endpackage

// File: rtl/acc_core_alu.sv
// Combinational execute stage: computes the next accumulator value and whether
// the executing opcode updates the accumulator at all.
module acc_core_alu
  import acc_core_pkg::*;
#(
  parameter int DW  = 8,
  parameter int OPW = 4
) (
  input  logic [3:0]     opcode,
  input  logic [DW-1:0]  acc,
  input  logic [DW-1:0]  mem,
  input  logic [OPW-1:0] op,
  output logic [DW-1:0]  alu_res,
  output logic           wr_acc
);

  logic [DW-1:0] imm;

  assign imm = DW'(signed'(op));

  always_comb begin
    alu_res = acc;
    wr_acc  = writes_acc(opcode);
    case (opcode)
      OP_ADD:  alu_res = acc + mem;
      OP_SUB:  alu_res = acc - mem;
      OP_SLL:  alu_res = acc << mem[2:0];
      OP_SRL:  alu_res = acc >> mem[2:0];
      OP_MUL:  alu_res = acc * mem;
      OP_NAND: alu_res = ~(acc & mem);
      OP_XOR:  alu_res = acc ^ mem;
      OP_ADDI: alu_res = acc + imm;
      OP_LI:   alu_res = imm;
      OP_SLLI: alu_res = acc << op[2:0];
      OP_CLR:  alu_res = '0;
      OP_LA:   alu_res = mem;
      default: alu_res = acc;
    endcase
  end

endmodule

// File: rtl/acc_core_prog.sv
// Two-stage accumulator core with writable instruction memory, run-control FSM
// (idle/run/step/halted) and a combinational debug read port into data memory.
module acc_core_prog
  import acc_core_pkg::*;
#(
  parameter int DW     = 8,
  parameter int IMEM_D = 16,
  parameter int DMEM_D = 15,
  parameter int OPW    = 4,
  localparam int PCW   = $clog2(IMEM_D),
  localparam int DAW   = $clog2(DMEM_D),
  localparam int IW    = OPW + 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           prog_we,
  input  logic [PCW-1:0] prog_addr,
  input  logic [IW-1:0]  prog_data,
  input  logic           start,
  input  logic           resume,
  input  logic           step,
  input  logic           halt_req,
  input  logic [DAW-1:0] dbg_addr,
  output logic [DW-1:0]  dbg_data,
  output logic [DW-1:0]  acc,
  output logic [PCW-1:0] pc,
  output logic [1:0]     state
);

  logic [IW-1:0]  imem [IMEM_D];
  logic [DW-1:0]  dmem [DMEM_D];

  run_state_t     state_q;
  logic [PCW-1:0] pc_q;
  logic [DW-1:0]  acc_q;
  logic [IW-1:0]  ir_q;
  logic           ir_valid_q;

  logic [3:0]     ir_opcode;
  logic [OPW-1:0] ir_op;
  logic [DAW-1:0] op_addr;
  logic           op_in_range;
  logic [DW-1:0]  mem_val;
  logic [DW-1:0]  alu_res;
  logic           wr_acc;
  logic           adv;
  logic           exec;
  logic           taken;
  logic           exec_halt;
  logic           exec_store;
  logic           prog_ok;

  assign ir_opcode   = ir_q[3:0];
  assign ir_op       = ir_q[IW-1:4];
  assign op_addr     = ir_op[DAW-1:0];
  assign op_in_range = 32'(ir_op) < DMEM_D;
  assign mem_val     = op_in_range ? dmem[op_addr] : '0;

  assign adv        = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign exec       = adv && (ir_valid_q == IR_VALID);
  assign taken      = exec && ((ir_opcode == OP_JMP) ||
                               ((ir_opcode == OP_BNZ) && (acc_q != '0)));
  assign exec_halt  = exec && (ir_opcode == OP_HALT);
  assign exec_store = exec && (ir_opcode == OP_SA) && op_in_range;
  assign prog_ok    = (state_q == ST_IDLE) || (state_q == ST_HALTED);

  assign dbg_data = (32'(dbg_addr) < DMEM_D) ? dmem[dbg_addr] : '0;
  assign acc      = acc_q;
  assign pc       = pc_q;
  assign state    = state_q;

  acc_core_alu #(
    .DW  (DW),
    .OPW (OPW)
  ) u_alu (
    .opcode  (ir_opcode),
    .acc     (acc_q),
    .mem     (mem_val),
    .op      (ir_op),
    .alu_res (alu_res),
    .wr_acc  (wr_acc)
  );

  // Program memory survives reset so a loaded program can be rerun after rst_n.
  always_ff @(posedge clk) begin
    if (prog_we && prog_ok) begin
      imem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DMEM_D; i++) begin
        dmem[i] <= '0;
      end
    end else if (exec_store) begin
      dmem[op_addr] <= acc_q;
    end
  end

  // HALT leaves pc at its own address+1 because the fetch behind it already happened.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      acc_q      <= '0;
      ir_q       <= '0;
      ir_valid_q <= IR_INVALID;
    end else begin
      case (state_q)
        ST_IDLE, ST_HALTED: begin
          if (start) begin
            state_q    <= ST_RUN;
            pc_q       <= '0;
            acc_q      <= '0;
            ir_valid_q <= IR_INVALID;
          end else if (resume && (state_q == ST_HALTED)) begin
            state_q <= ST_RUN;
          end else if (step) begin
            state_q <= ST_STEP;
          end
        end
        ST_RUN, ST_STEP: begin
          if (exec && wr_acc) begin
            acc_q <= alu_res;
          end
          if (taken) begin
            pc_q       <= ir_op[PCW-1:0];
            ir_valid_q <= IR_INVALID;
          end else if (exec_halt) begin
            ir_valid_q <= IR_INVALID;
          end else begin
            ir_q       <= imem[pc_q];
            ir_valid_q <= IR_VALID;
            pc_q       <= pc_q + PCW'(1);
          end
          if ((state_q == ST_RUN) && (exec_halt || halt_req)) begin
            state_q <= ST_HALTED;
          end else if ((state_q == ST_STEP) && (ir_valid_q == IR_VALID)) begin
            state_q <= ST_HALTED;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_core_prog.sv
// Randomized and directed bench for acc_core_prog, checked every cycle against an
// instruction-level model of the core plus hand-computed program results.
`timescale 1ns/1ps
module tb_acc_core_prog;

  localparam int O_ADD = 0,  O_SUB = 1,  O_SLL = 2,  O_BNZ = 3;
  localparam int O_SRL = 4,  O_MUL = 5,  O_NAND = 6, O_XOR = 7;
  localparam int O_ADDI = 8, O_LI = 9,   O_SLLI = 10, O_JMP = 11;
  localparam int O_HALT = 12, O_CLR = 13, O_LA = 14, O_SA = 15;
  localparam int S_IDLE = 0, S_RUN = 1, S_STEP = 2, S_HALTED = 3;

  logic       clk;
  logic       rst_n;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       start;
  logic       resume;
  logic       step;
  logic       halt_req;
  logic [3:0] dbg_addr;
  logic [7:0] dbg_data;
  logic [7:0] acc;
  logic [3:0] pc;
  logic [1:0] state;

  int  checks = 0;
  int  failures = 0;
  bit  cmp_en = 0;

  int  m_imem [16];
  int  m_dmem [15];
  int  m_state, m_pc, m_acc, m_ir;
  bit  m_irv;

  logic [7:0] pbuf [16];
  int  n;

  acc_core_prog #(
    .DW(8), .IMEM_D(16), .DMEM_D(15), .OPW(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .resume(resume), .step(step),
    .halt_req(halt_req), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .acc(acc), .pc(pc), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level reference: one call per clock edge, acting on whole instructions.
  task automatic modelReset();
    m_state = S_IDLE; m_pc = 0; m_acc = 0; m_ir = 0; m_irv = 0;
    for (int i = 0; i < 15; i++) m_dmem[i] = 0;
  endtask

  function automatic int modelDbg(input logic [3:0] a);
    return (a < 15) ? m_dmem[a] : 0;
  endfunction

  task automatic modelStep();
    int opc, opd, memv, imm, nacc;
    bit taken, hlt, retired;
    if (m_state == S_IDLE || m_state == S_HALTED) begin
      if (prog_we) m_imem[prog_addr] = prog_data;
      if (start) begin
        m_state = S_RUN; m_pc = 0; m_acc = 0; m_irv = 0;
      end else if (resume && m_state == S_HALTED) begin
        m_state = S_RUN;
      end else if (step) begin
        m_state = S_STEP;
      end
    end else begin
      taken = 0; hlt = 0; opd = 0; nacc = m_acc; retired = m_irv;
      if (m_irv) begin
        opc  = m_ir % 16;
        opd  = m_ir / 16;
        memv = (opd < 15) ? m_dmem[opd] : 0;
        imm  = (opd >= 8) ? opd - 16 : opd;
        case (opc)
          O_ADD:  nacc = m_acc + memv;
          O_SUB:  nacc = m_acc - memv;
          O_SLL:  nacc = m_acc << (memv % 8);
          O_BNZ:  taken = (m_acc != 0);
          O_SRL:  nacc = m_acc >> (memv % 8);
          O_MUL:  nacc = m_acc * memv;
          O_NAND: nacc = ~(m_acc & memv);
          O_XOR:  nacc = m_acc ^ memv;
          O_ADDI: nacc = m_acc + imm;
          O_LI:   nacc = imm;
          O_SLLI: nacc = m_acc << (opd % 8);
          O_JMP:  taken = 1;
          O_HALT: hlt = 1;
          O_CLR:  nacc = 0;
          O_LA:   nacc = memv;
          O_SA:   if (opd < 15) m_dmem[opd] = m_acc;
          default: ;
        endcase
      end
      if (taken) begin
        m_pc = opd % 16; m_irv = 0;
      end else if (hlt) begin
        m_irv = 0;
      end else begin
        m_ir = m_imem[m_pc]; m_irv = 1; m_pc = (m_pc + 1) % 16;
      end
      if (m_state == S_RUN && (hlt || halt_req)) m_state = S_HALTED;
      else if (m_state == S_STEP && retired) m_state = S_HALTED;
      m_acc = nacc & 255;
    end
  endtask

  always @(negedge rst_n) modelReset();

  always @(posedge clk) begin
    if (rst_n) modelStep();
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("cyc_state", 32'(state), m_state);
      checkOutput("cyc_pc", 32'(pc), m_pc);
      checkOutput("cyc_acc", 32'(acc), m_acc);
      checkOutput("cyc_dbg", 32'(dbg_data), modelDbg(dbg_addr));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] ins(input int opc, input int opd);
    return 8'(((opd & 15) << 4) | (opc & 15));
  endfunction

  task automatic clearBuf();
    for (int i = 0; i < 16; i++) pbuf[i] = ins(O_HALT, 0);
  endtask

  task automatic loadBuf();
    for (int i = 0; i < 16; i++) begin
      prog_we = 1'b1; prog_addr = 4'(i); prog_data = pbuf[i];
      tick();
    end
    prog_we = 1'b0;
  endtask

  task automatic applyStimulus(input bit s, input bit r, input bit st, input bit h);
    start = s; resume = r; step = st; halt_req = h;
    tick();
    start = 0; resume = 0; step = 0; halt_req = 0;
  endtask

  task automatic runWhile(input int st, input int maxc, output int cnt);
    cnt = 0;
    while (state == 2'(st) && cnt < maxc) begin
      cnt++;
      tick();
    end
    checks++;
    if (cnt >= maxc) begin
      failures++;
      $display("[TB] FAIL run_bound: state %0d lasted %0d cycles, required fewer", st, cnt);
    end
  endtask

  task automatic checkDbg(input string name, input logic [3:0] a, input int exp);
    dbg_addr = a;
    tick();
    checkOutput(name, 32'(dbg_data), exp);
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic settle();
    start = 0; resume = 0; step = 0; halt_req = 0; prog_we = 0;
    for (int k = 0; k < 4; k++) begin
      if (state == 2'(S_RUN)) applyStimulus(0, 0, 0, 1);
      else if (state == 2'(S_STEP)) tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; prog_we = 0; prog_addr = 0; prog_data = 0;
    start = 0; resume = 0; step = 0; halt_req = 0; dbg_addr = 4'd3;
    for (int i = 0; i < 16; i++) m_imem[i] = 0;
    modelReset();
    repeat (3) tick();
    checkOutput("reset_state", 32'(state), S_IDLE);
    checkOutput("reset_pc", 32'(pc), 0);
    checkOutput("reset_acc", 32'(acc), 0);
    checkOutput("reset_dbg", 32'(dbg_data), 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    tick();

    // LI 5; SA 2; HALT
    clearBuf();
    pbuf[0] = ins(O_LI, 5); pbuf[1] = ins(O_SA, 2); pbuf[2] = ins(O_HALT, 0);
    loadBuf();
    applyStimulus(1, 0, 0, 0);
    runWhile(S_RUN, 50, n);
    checkOutput("p1_run_cycles", n, 4);
    checkOutput("p1_state", 32'(state), S_HALTED);
    checkOutput("p1_pc", 32'(pc), 3);
    checkOutput("p1_acc", 32'(acc), 8'h05);
    checkDbg("p1_dmem2", 4'd2, 8'h05);

    // Countdown: two taken BNZ bubbles give 12 RUN cycles
    clearBuf();
    pbuf[0] = ins(O_LI, 3); pbuf[1] = ins(O_ADDI, -1); pbuf[2] = ins(O_BNZ, 1);
    pbuf[3] = ins(O_SA, 0); pbuf[4] = ins(O_HALT, 0);
    loadBuf();
    applyStimulus(1, 0, 0, 0);
    runWhile(S_RUN, 100, n);
    checkOutput("cd_run_cycles", n, 12);
    checkOutput("cd_pc", 32'(pc), 5);
    checkOutput("cd_acc", 32'(acc), 0);
    checkDbg("cd_dmem0", 4'd0, 0);

    // Single-stepping from IDLE
    pulseReset();
    clearBuf();
    pbuf[0] = ins(O_LI, 7); pbuf[1] = ins(O_ADDI, 1); pbuf[2] = ins(O_SA, 4);
    loadBuf();
    applyStimulus(0, 0, 1, 0);
    runWhile(S_STEP, 10, n);
    checkOutput("step1_cycles", n, 2);
    checkOutput("step1_acc", 32'(acc), 8'h07);
    checkOutput("step1_state", 32'(state), S_HALTED);
    applyStimulus(0, 0, 1, 0);
    runWhile(S_STEP, 10, n);
    checkOutput("step2_cycles", n, 1);
    checkOutput("step2_acc", 32'(acc), 8'h08);
    applyStimulus(0, 0, 1, 0);
    runWhile(S_STEP, 10, n);
    checkOutput("step3_state", 32'(state), S_HALTED);
    checkOutput("step3_pc", 32'(pc), 4);
    checkDbg("step3_dmem4", 4'd4, 8'h08);

    // Loop with SA/LA back to back, run straight through then interrupted
    clearBuf();
    pbuf[0] = ins(O_LI, 5);   pbuf[1] = ins(O_SA, 1);  pbuf[2] = ins(O_LA, 1);
    pbuf[3] = ins(O_ADDI, -1); pbuf[4] = ins(O_SA, 1); pbuf[5] = ins(O_BNZ, 2);
    pbuf[6] = ins(O_LI, 6);   pbuf[7] = ins(O_SA, 3);  pbuf[8] = ins(O_HALT, 0);
    loadBuf();
    applyStimulus(1, 0, 0, 0);
    runWhile(S_RUN, 200, n);
    checkOutput("loop_acc", 32'(acc), 8'h06);
    checkOutput("loop_pc", 32'(pc), 9);
    checkDbg("loop_dmem3", 4'd3, 8'h06);
    checkDbg("loop_dmem1", 4'd1, 0);
    pulseReset();
    applyStimulus(1, 0, 0, 0);
    prog_we = 1'b1; prog_addr = 4'd6; prog_data = ins(O_LI, 2);
    repeat (6) tick();
    prog_we = 1'b0;
    applyStimulus(0, 0, 0, 1);
    checkOutput("hreq_state", 32'(state), S_HALTED);
    repeat (3) tick();
    applyStimulus(0, 1, 0, 0);
    runWhile(S_RUN, 200, n);
    checkOutput("resume_acc", 32'(acc), 8'h06);
    checkDbg("resume_dmem3", 4'd3, 8'h06);
    checkDbg("resume_dmem1", 4'd1, 0);

    // Out-of-range data address and MUL overflow
    clearBuf();
    pbuf[0] = ins(O_LI, 7);  pbuf[1] = ins(O_SA, 15); pbuf[2] = ins(O_LA, 15);
    pbuf[3] = ins(O_ADDI, 1); pbuf[4] = ins(O_SA, 6); pbuf[5] = ins(O_LI, 1);
    pbuf[6] = ins(O_SLLI, 4); pbuf[7] = ins(O_SA, 5); pbuf[8] = ins(O_CLR, 0);
    pbuf[9] = ins(O_LA, 5);  pbuf[10] = ins(O_MUL, 5); pbuf[11] = ins(O_HALT, 0);
    loadBuf();
    applyStimulus(1, 0, 0, 0);
    runWhile(S_RUN, 100, n);
    checkOutput("bnd_mul_acc", 32'(acc), 8'h00);
    checkOutput("bnd_pc", 32'(pc), 12);
    checkDbg("bnd_dmem6", 4'd6, 8'h01);
    checkDbg("bnd_dmem5", 4'd5, 8'h10);
    checkDbg("bnd_dbg15", 4'd15, 0);

    // Random programs and random run-control traffic
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) pbuf[i] = 8'($urandom);
      loadBuf();
      for (int c = 0; c < 300; c++) begin
        start     = ($urandom_range(0, 39) == 0);
        resume    = ($urandom_range(0, 9) == 0);
        step      = ($urandom_range(0, 9) == 0);
        halt_req  = ($urandom_range(0, 19) == 0);
        prog_we   = ($urandom_range(0, 7) == 0);
        prog_addr = 4'($urandom);
        prog_data = 8'($urandom);
        dbg_addr  = 4'($urandom);
        tick();
      end
      settle();
    end

    // Asynchronous reset in the middle of a run; imem must survive it
    clearBuf();
    pbuf[0] = ins(O_LI, 5); pbuf[1] = ins(O_SA, 2); pbuf[2] = ins(O_JMP, 0);
    loadBuf();
    applyStimulus(1, 0, 0, 0);
    repeat (5) tick();
    checkDbg("ar_pre_dmem2", 4'd2, 8'h05);
    checkOutput("ar_pre_state", 32'(state), S_RUN);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_state", 32'(state), S_IDLE);
    checkOutput("ar_acc", 32'(acc), 0);
    checkOutput("ar_pc", 32'(pc), 0);
    checkOutput("ar_dmem2", 32'(dbg_data), 0);
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(0, 0, 1, 0);
    runWhile(S_STEP, 10, n);
    checkOutput("ar_step_cycles", n, 2);
    checkOutput("ar_step_acc", 32'(acc), 8'h05);
    checkOutput("ar_step_pc", 32'(pc), 2);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
